accum_cpu_seq: RTL and testbench

Parametrised accumulator micro-CPU with a fixed four-phase micro-sequence per instruction. It fetches opcodes and operands over a narrow address/data memory port. It extends the six-bit accumulator design with:
- configurable data width
- carry flag, subtract and conditional-on-carry jump
- HALT
- an optional hardware return-address stack (CALL/RET)

It sits behind the TinyTapeout-style I/O wrapper, driven by an external program memory.

---
 rtl/accum_cpu_seq.sv | 152 +++++++++++++++
 tb/tb_accum_cpu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/accum_cpu_seq.sv
// Accumulator micro-CPU with a fixed F0/F1/E0/E1 sequence per instruction.
// Define ACCUM_CPU_CALL_STACK_EN to build in the CALL/RET return-address stack.
module accum_cpu_seq #(
    parameter int DATA_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] mem_in,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              stack_err
);

    localparam logic [1:0] PH_F0 = 2'd0;
    localparam logic [1:0] PH_F1 = 2'd1;
    localparam logic [1:0] PH_E0 = 2'd2;
    localparam logic [1:0] PH_E1 = 2'd3;

    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);
    localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(1);
    localparam logic [DATA_W-1:0] OP_SWAP = DATA_W'(2);
    localparam logic [DATA_W-1:0] OP_LDC  = DATA_W'(3);
    localparam logic [DATA_W-1:0] OP_STC  = DATA_W'(4);
    localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(5);
    localparam logic [DATA_W-1:0] OP_JNZ  = DATA_W'(6);
    localparam logic [DATA_W-1:0] OP_LDI  = DATA_W'(7);
    localparam logic [DATA_W-1:0] OP_INC  = DATA_W'(8);
    localparam logic [DATA_W-1:0] OP_NOT  = DATA_W'(9);
    localparam logic [DATA_W-1:0] OP_SUB  = DATA_W'(10);
    localparam logic [DATA_W-1:0] OP_JC   = DATA_W'(11);
    localparam logic [DATA_W-1:0] OP_CALL = DATA_W'(12);
    localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(14);
    localparam logic [DATA_W-1:0] OP_OUT  = DATA_W'(16);

    if (DATA_W < 5 || STACK_DEPTH < 1) begin : g_param_check
        $error("accum_cpu_seq: DATA_W must be >= 5 and STACK_DEPTH >= 1");
    end

    logic [DATA_W-1:0] a, b, c, pc, instr;
    logic [1:0]        phase;
    logic              carry;

`ifdef ACCUM_CPU_CALL_STACK_EN
    localparam logic [DATA_W-1:0] OP_RET = DATA_W'(13);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

    // Padded to a power of two so SP can index the array at its own width.
    logic [DATA_W-1:0] stack [2**SP_W];
    logic [SP_W-1:0]   sp;
`else
    assign stack_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a         <= ONE;
            b         <= ONE;
            c         <= '0;
            pc        <= '0;
            instr     <= '0;
            phase     <= PH_F0;
            carry     <= 1'b0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
`ifdef ACCUM_CPU_CALL_STACK_EN
            sp        <= '0;
            stack_err <= 1'b0;
            for (int unsigned i = 0; i < 2**SP_W; i++) stack[i] <= '0;
`endif
        end else if (!halted) begin
            case (phase)
                PH_F0: begin
                    mem_addr <= pc;
                    pc       <= pc + ONE;
                    phase    <= PH_F1;
                end
                PH_F1: begin
                    instr <= mem_in;
                    phase <= PH_E0;
                end
                PH_E0: begin
                    phase <= PH_E1;
                    case (instr)
                        OP_ADD:  {carry, a} <= {1'b0, a} + {1'b0, b};
                        OP_SWAP: begin
                            a <= b;
                            b <= a;
                        end
                        OP_LDC:  a <= c;
                        OP_STC:  c <= a;
                        OP_INC:  {carry, a} <= {1'b0, a} + {1'b0, ONE};
                        OP_NOT:  a <= ~a;
                        OP_SUB:  {carry, a} <= {1'b0, a} - {1'b0, b};
                        OP_HALT: halted <= 1'b1;
                        OP_OUT: begin
                            out_data  <= a;
                            out_valid <= 1'b1;
                        end
                        OP_JMP, OP_JNZ, OP_LDI, OP_JC, OP_CALL: mem_addr <= pc;
`ifdef ACCUM_CPU_CALL_STACK_EN
                        OP_RET: begin
                            if (sp != '0) begin
                                pc <= stack[sp - SP_ONE];
                                sp <= sp - SP_ONE;
                            end else begin
                                stack_err <= 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                default: begin
                    out_valid <= 1'b0;
                    phase     <= PH_F0;
                    case (instr)
                        OP_JMP: pc <= mem_in;
                        OP_JNZ: pc <= (a != '0) ? mem_in : pc + ONE;
                        OP_LDI: begin
                            a  <= mem_in;
                            pc <= pc + ONE;
                        end
                        OP_JC:  pc <= carry ? mem_in : pc + ONE;
`ifdef ACCUM_CPU_CALL_STACK_EN
                        OP_CALL: begin
                            if (sp != SP_FULL) begin
                                stack[sp] <= pc + ONE;
                                sp        <= sp + SP_ONE;
                                pc        <= mem_in;
                            end else begin
                                pc        <= pc + ONE;
                                stack_err <= 1'b1;
                            end
                        end
`else
                        OP_CALL: pc <= pc + ONE;
`endif
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_cpu_seq.sv
// Directed, table-driven bench for accum_cpu_seq with a combinational program memory.
module tb_accum_cpu_seq;

    localparam int DW = 6;

    typedef int prog_t [32];
    typedef struct {
        string name;
        prog_t prog;
        int    first;
        int    last;
        int    count;
        int    addr;
        int    err;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] mem_in, mem_addr, out_data;
    logic          out_valid, halted, stack_err;
    logic [DW-1:0] mem [64];

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    accum_cpu_seq #(.DATA_W(DW), .STACK_DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_in    (mem_in),
        .mem_addr  (mem_addr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .stack_err (stack_err)
    );

    assign mem_in = mem[mem_addr];
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input prog_t p, input int first, input int last,
                       input int count, input int addr, input int err);
        vec_t v;
        v.name = name; v.prog = p; v.first = first; v.last = last;
        v.count = count; v.addr = addr; v.err = err;
        vq.push_back(v);
    endtask

    task automatic load(input prog_t p);
        for (int i = 0; i < 64; i++) mem[i] = (i < 32) ? DW'(p[i]) : '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, output int cnt, output int first, output int last);
        cnt = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            if (out_valid) begin
                if (cnt == 0) first = int'(out_data);
                last = int'(out_data);
                cnt++;
            end
            if (halted) break;
        end
        check({name, ":halted"}, int'(halted), 1);
    endtask

    initial begin
        int cnt, first, last;
        prog_t p;

        for (int i = 0; i < 64; i++) mem[i] = '0;

        add("inc_out",  '{0:8, 1:16, 2:14, default:0}, 2, 2, 1, 2, 0);
        add("jc_taken", '{0:7, 1:63, 2:8, 3:11, 4:6, 5:2, 6:16, 7:14, default:0}, 0, 0, 1, 7, 0);
        add("jc_fall",  '{0:7, 1:62, 2:8, 3:11, 4:6, 5:2, 6:16, 7:14, default:0}, 1, 1, 1, 7, 0);
        add("sub_jnz",  '{0:10, 1:11, 2:14, 3:10, 4:11, 5:8, 6:14, 7:14, 8:6, 9:12,
                          10:14, 11:14, 12:16, 13:14, 14:14, default:0}, 63, 63, 1, 13, 0);
        add("add_jc",   '{0:7, 1:62, 2:1, 3:1, 4:11, 5:8, 6:14, 8:16, 9:14, default:0}, 0, 0, 1, 9, 0);
        add("moves",    '{0:7, 1:5, 2:2, 3:4, 4:2, 5:1, 6:16, 7:3, 8:16, 9:14, default:0}, 6, 1, 2, 9, 0);
        add("not_jmp",  '{0:9, 1:5, 2:6, 3:14, 6:48, 7:16, 8:7, 9:0, 10:6, 11:3,
                          12:16, 13:14, default:0}, 62, 0, 2, 13, 0);
`ifdef ACCUM_CPU_CALL_STACK_EN
        add("nested",   '{0:12, 1:10, 2:13, 3:16, 4:14, 10:8, 11:12, 12:20, 13:13,
                          20:8, 21:12, 22:30, 23:8, 24:13, 30:14, default:0}, 4, 4, 1, 4, 1);
        add("ret_empty", '{0:13, 1:16, 2:14, default:0}, 1, 1, 1, 2, 1);
`else
        add("call_nop", '{0:12, 1:9, 2:8, 3:16, 4:14, default:0}, 2, 2, 1, 4, 0);
`endif

        // Reset state, sampled while reset_n is held low.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:mem_addr",  int'(mem_addr), 0);
        check("rst:out_data",  int'(out_data), 0);
        check("rst:out_valid", int'(out_valid), 0);
        check("rst:halted",    int'(halted), 0);
        check("rst:stack_err", int'(stack_err), 0);

        foreach (vq[k]) begin
            load(vq[k].prog);
            do_reset();
            run(vq[k].name, cnt, first, last);
            check({vq[k].name, ":out_count"}, cnt, vq[k].count);
            check({vq[k].name, ":first_out"}, first, vq[k].first);
            check({vq[k].name, ":last_out"},  last, vq[k].last);
            check({vq[k].name, ":halt_addr"}, int'(mem_addr), vq[k].addr);
            check({vq[k].name, ":stack_err"}, int'(stack_err), vq[k].err);
        end

        // Cycle-exact OUT pulse and HALT freeze.
        p = '{0:8, 1:16, 2:14, default:0};
        load(p);
        do_reset();
        repeat (6) step();
        check("cyc6:out_valid", int'(out_valid), 0);
        step();
        check("cyc7:out_valid", int'(out_valid), 1);
        check("cyc7:out_data",  int'(out_data), 2);
        step();
        check("cyc8:out_valid", int'(out_valid), 0);
        repeat (2) step();
        check("cyc10:halted", int'(halted), 0);
        step();
        check("cyc11:halted", int'(halted), 1);
        repeat (6) step();
        check("frozen:mem_addr",  int'(mem_addr), 2);
        check("frozen:out_valid", int'(out_valid), 0);
        check("frozen:out_data",  int'(out_data), 2);
        check("frozen:halted",    int'(halted), 1);

        // PC wrap on fetch and on the LDI operand increment.
        p = '{0:5, 1:62, 2:16, 3:14, default:0};
        load(p);
        mem[62] = DW'(8);
        mem[63] = DW'(7);
        do_reset();
        run("wrap", cnt, first, last);
        check("wrap:out_count", cnt, 1);
        check("wrap:out",       last, 5);
        check("wrap:halt_addr", int'(mem_addr), 3);

        // Reset asserted during the E1 phase of LDI.
        p = '{0:8, 1:16, 2:7, 3:42, 4:16, 5:14, default:0};
        load(p);
        do_reset();
        repeat (11) step();
        check("midrst:pre_addr", int'(mem_addr), 3);
        check("midrst:pre_out",  int'(out_data), 2);
        #2 reset_n = 1'b0;
        #1;
        check("midrst:mem_addr",  int'(mem_addr), 0);
        check("midrst:out_data",  int'(out_data), 0);
        check("midrst:out_valid", int'(out_valid), 0);
        check("midrst:halted",    int'(halted), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run("midrst", cnt, first, last);
        check("midrst:out_count", cnt, 2);
        check("midrst:first_out", first, 2);
        check("midrst:last_out",  last, 42);
        check("midrst:halt_addr", int'(mem_addr), 5);

`ifdef ACCUM_CPU_CALL_STACK_EN
        // Overflowing CALL is the fifth instruction; its E1 edge is edge 20.
        p = '{0:12, 1:10, 2:13, 3:16, 4:14, 10:8, 11:12, 12:20, 13:13,
              20:8, 21:12, 22:30, 23:8, 24:13, 30:14, default:0};
        load(p);
        do_reset();
        repeat (19) step();
        check("ovf:err_before", int'(stack_err), 0);
        step();
        check("ovf:err_after", int'(stack_err), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
